// File: rtl/read_req_splitter.sv
// rtl/read_req_splitter.sv - splits read commands into 4 KB-safe bursts, reserving read_info before each address (optional stats: READ_REQ_STATS_EN)
module read_req_splitter #(
    parameter int NUM_PU     = 1,
    parameter int D_TYPE_W   = 2,
    parameter int RD_SIZE_W  = 20,
    parameter int ADDR_W     = 32,
    parameter int BURST_W    = 8,
    parameter int BEAT_BYTES = 8,
    parameter int MAX_BURST  = 16,
    parameter int PU_ID_W    = $clog2(NUM_PU) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [RD_SIZE_W-1:0] cmd_size,
    input  logic [PU_ID_W-1:0]   cmd_pu_id,
    input  logic [D_TYPE_W-1:0]  cmd_d_type,
    input  logic                 read_info_full,
    output logic                 rd_req,
    output logic [RD_SIZE_W-1:0] rd_req_size,
    output logic [PU_ID_W-1:0]   rd_req_pu_id,
    output logic [D_TYPE_W-1:0]  rd_req_d_type,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_W-1:0]    ar_addr,
    output logic [BURST_W-1:0]   ar_len,
    output logic                 done,
    output logic [31:0]          stat_bursts,
    output logic [31:0]          stat_stall_cycles
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BL_W       = BURST_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESV,
        S_ADDR
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
    logic [RD_SIZE_W-1:0] remaining_q, remaining_d;
    logic [PU_ID_W-1:0]   pu_id_q, pu_id_d;
    logic [D_TYPE_W-1:0]  d_type_q, d_type_d;
    logic [BL_W-1:0]      burst_q, burst_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]    ar_addr_q, ar_addr_d;
    logic [BURST_W-1:0]   ar_len_q, ar_len_d;
    logic                 done_q, done_d;
    logic [31:0]          rem_w, bnd_w, lim_w;

    // Next-state and registered-output logic for the split/reserve/address sequence
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        pu_id_d     = pu_id_q;
        d_type_d    = d_type_q;
        burst_d     = burst_q;
        cmd_ready_d = cmd_ready_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        done_d      = 1'b0;
        rem_w       = 32'(remaining_q);
        bnd_w       = 32'((13'h1000 - {1'b0, cur_addr_q[11:0]}) >> BEAT_SHIFT);
        lim_w       = 32'(MAX_BURST);
        if (rem_w < lim_w) lim_w = rem_w;
        if (bnd_w < lim_w) lim_w = bnd_w;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cur_addr_d  = cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
                    remaining_d = cmd_size;
                    pu_id_d     = cmd_pu_id;
                    d_type_d    = cmd_d_type;
                    if (cmd_size == '0) begin
                        // Empty command completes at once; stay ready for the next one
                        done_d = 1'b1;
                    end else begin
                        cmd_ready_d = 1'b0;
                        state_d     = S_CALC;
                    end
                end
            end
            S_CALC: begin
                burst_d = BL_W'(lim_w);
                state_d = S_RESV;
            end
            S_RESV: begin
                if (!read_info_full) begin
                    ar_valid_d = 1'b1;
                    ar_addr_d  = cur_addr_q;
                    ar_len_d   = BURST_W'(burst_q - BL_W'(1));
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_ready) begin
                    ar_valid_d  = 1'b0;
                    cur_addr_d  = cur_addr_q + (ADDR_W'(burst_q) << BEAT_SHIFT);
                    remaining_d = remaining_q - RD_SIZE_W'(burst_q);
                    if (remaining_q == RD_SIZE_W'(burst_q)) begin
                        done_d      = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            pu_id_q     <= '0;
            d_type_q    <= '0;
            burst_q     <= '0;
            cmd_ready_q <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            pu_id_q     <= pu_id_d;
            d_type_q    <= d_type_d;
            burst_q     <= burst_d;
            cmd_ready_q <= cmd_ready_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            done_q      <= done_d;
        end
    end

    // Reservation is the only combinational output so read_info sees it in the same cycle
    assign rd_req        = (state_q == S_RESV) && !read_info_full;
    assign rd_req_size   = RD_SIZE_W'(burst_q);
    assign rd_req_pu_id  = pu_id_q;
    assign rd_req_d_type = d_type_q;
    assign cmd_ready     = cmd_ready_q;
    assign ar_valid      = ar_valid_q;
    assign ar_addr       = ar_addr_q;
    assign ar_len        = ar_len_q;
    assign done          = done_q;

`ifdef READ_REQ_STATS_EN
    logic [31:0] stat_bursts_q, stat_bursts_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating counters for issued bursts and back-pressure cycles
    always_comb begin
        stat_bursts_d = stat_bursts_q;
        stat_stall_d  = stat_stall_q;
        if (state_q == S_ADDR && ar_ready && stat_bursts_q != 32'hFFFF_FFFF)
            stat_bursts_d = stat_bursts_q + 32'd1;
        if (((state_q == S_RESV && read_info_full) || (state_q == S_ADDR && !ar_ready))
            && stat_stall_q != 32'hFFFF_FFFF)
            stat_stall_d = stat_stall_q + 32'd1;
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_bursts_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_bursts_q <= stat_bursts_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_bursts       = stat_bursts_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    assign stat_bursts       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_read_req_splitter.sv
// tb/tb_read_req_splitter.sv - self-checking bench for read_req_splitter against a burst-splitting reference model
module tb_read_req_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [19:0] cmd_size = '0;
    logic [0:0]  cmd_pu_id = '0;
    logic [1:0]  cmd_d_type = '0;
    logic        read_info_full = 1'b0;
    logic        rd_req;
    logic [19:0] rd_req_size;
    logic [0:0]  rd_req_pu_id;
    logic [1:0]  rd_req_d_type;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        done;
    logic [31:0] stat_bursts;
    logic [31:0] stat_stall_cycles;

    int     checks = 0;
    int     errors = 0;
    longint exp_bursts = 0;
    longint exp_stall = 0;

    read_req_splitter dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_size          (cmd_size),
        .cmd_pu_id         (cmd_pu_id),
        .cmd_d_type        (cmd_d_type),
        .read_info_full    (read_info_full),
        .rd_req            (rd_req),
        .rd_req_size       (rd_req_size),
        .rd_req_pu_id      (rd_req_pu_id),
        .rd_req_d_type     (rd_req_d_type),
        .ar_valid          (ar_valid),
        .ar_ready          (ar_ready),
        .ar_addr           (ar_addr),
        .ar_len            (ar_len),
        .done              (done),
        .stat_bursts       (stat_bursts),
        .stat_stall_cycles (stat_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef READ_REQ_STATS_EN
        check("stat_bursts", 64'(stat_bursts), 64'(exp_bursts));
        check("stat_stall_cycles", 64'(stat_stall_cycles), 64'(exp_stall));
`else
        check("stat_bursts_off", 64'(stat_bursts), 64'd0);
        check("stat_stall_off", 64'(stat_stall_cycles), 64'd0);
`endif
    endtask

    // fpct: percent of RESV cycles with read_info_full; rpct: percent of ADDR cycles with ar_ready low.
    // fhold/rhold force that many leading stall cycles on the first burst.
    task automatic run_cmd(input logic [31:0] addr, input logic [19:0] size, input logic [0:0] pu,
                           input logic [1:0] dt, input int fpct, input int rpct,
                           input int fhold, input int rhold);
        logic [31:0] ea[$];
        int          eb[$];
        logic [31:0] a;
        int          rem, b, bnd, k;
        a   = addr & ~32'd7;
        rem = int'(size);
        while (rem > 0) begin
            bnd = (4096 - int'(a % 32'd4096)) / 8;
            b = rem;
            if (b > 16) b = 16;
            if (b > bnd) b = bnd;
            ea.push_back(a);
            eb.push_back(b);
            a   = a + 32'(b * 8);
            rem = rem - b;
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_size = size; cmd_pu_id = pu; cmd_d_type = dt;
        read_info_full = 1'b0; ar_ready = 1'b0;
        #1;
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle_done", 64'(done), 64'd0);
        @(posedge clk);

        if (size == 20'd0) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            check("zero_done", 64'(done), 64'd1);
            check("zero_cmd_ready", 64'(cmd_ready), 64'd1);
            check("zero_rd_req", 64'(rd_req), 64'd0);
            check("zero_ar_valid", 64'(ar_valid), 64'd0);
            @(negedge clk);
            #1;
            check("zero_done_pulse", 64'(done), 64'd0);
            check("zero_no_ar_valid", 64'(ar_valid), 64'd0);
            check_stats();
            return;
        end

        for (int i = 0; i < eb.size(); i++) begin
            // burst-size calculation cycle
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            cmd_size  = 20'($urandom);
            read_info_full = 1'($urandom_range(1));
            ar_ready       = 1'($urandom_range(1));
            #1;
            check("calc_rd_req", 64'(rd_req), 64'd0);
            check("calc_ar_valid", 64'(ar_valid), 64'd0);
            check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
            check("busy_done", 64'(done), 64'd0);
            @(posedge clk);

            // reservation phase
            k = 0;
            forever begin
                @(negedge clk);
                if (i == 0 && k < fhold) read_info_full = 1'b1;
                else read_info_full = (k < 40) && ($urandom_range(99) < 32'(fpct));
                ar_ready = 1'($urandom_range(1));
                #1;
                check("resv_ar_valid", 64'(ar_valid), 64'd0);
                if (read_info_full) begin
                    check("resv_full_rd_req", 64'(rd_req), 64'd0);
                    exp_stall++;
                end else begin
                    check("resv_rd_req", 64'(rd_req), 64'd1);
                    check("rd_req_size", 64'(rd_req_size), 64'(eb[i]));
                    check("rd_req_pu_id", 64'(rd_req_pu_id), 64'(pu));
                    check("rd_req_d_type", 64'(rd_req_d_type), 64'(dt));
                end
                k++;
                @(posedge clk);
                if (!read_info_full) break;
            end

            // address phase
            k = 0;
            forever begin
                @(negedge clk);
                if (i == 0 && k < rhold) ar_ready = 1'b0;
                else ar_ready = (k >= 40) || ($urandom_range(99) >= 32'(rpct));
                read_info_full = 1'($urandom_range(1));
                #1;
                check("addr_ar_valid", 64'(ar_valid), 64'd1);
                check("addr_ar_addr", 64'(ar_addr), 64'(ea[i]));
                check("addr_ar_len", 64'(ar_len), 64'(eb[i] - 1));
                check("addr_no_rd_req", 64'(rd_req), 64'd0);
                if (!ar_ready) exp_stall++;
                k++;
                @(posedge clk);
                if (ar_ready) break;
            end
            exp_bursts++;
        end

        @(negedge clk);
        read_info_full = 1'b0; ar_ready = 1'b0;
        #1;
        check("end_done", 64'(done), 64'd1);
        check("end_cmd_ready", 64'(cmd_ready), 64'd1);
        check("end_ar_valid", 64'(ar_valid), 64'd0);
        check("end_rd_req", 64'(rd_req), 64'd0);
        check_stats();
    endtask

    initial begin
        logic [31:0] ra;
        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_ar_addr", 64'(ar_addr), 64'd0);
        check("rst_ar_len", 64'(ar_len), 64'd0);
        check("rst_rd_req_size", 64'(rd_req_size), 64'd0);
        check("rst_rd_req_pu_id", 64'(rd_req_pu_id), 64'd0);
        check("rst_rd_req_d_type", 64'(rd_req_d_type), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_stats();
        @(negedge clk);
        reset = 1'b0;

        run_cmd(32'h0000_1000, 20'd40, 1'b1, 2'd2, 0, 0, 0, 0);
        run_cmd(32'h0000_1FC0, 20'd20, 1'b0, 2'd1, 0, 0, 5, 3);
        run_cmd(32'h0000_5008, 20'd0, 1'b1, 2'd3, 0, 0, 0, 0);
        run_cmd(32'h0000_1005, 20'd3, 1'b0, 2'd3, 0, 0, 0, 0);
        run_cmd(32'hFFFF_FF80, 20'd40, 1'b1, 2'd0, 20, 20, 0, 0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            if ($urandom_range(1) == 1) ra[11:8] = 4'hF;
            run_cmd(ra, 20'($urandom_range(70)), 1'($urandom_range(1)), 2'($urandom_range(3)),
                    30, 30, 0, 0);
        end

        // reset while an address is outstanding
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_3000; cmd_size = 20'd40;
        cmd_pu_id = 1'b1; cmd_d_type = 2'd1; read_info_full = 1'b0; ar_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_ar_valid", 64'(ar_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_ar_valid", 64'(ar_valid), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst_rd_req", 64'(rd_req), 64'd0);
        check("midrst_ar_addr", 64'(ar_addr), 64'd0);
        check("midrst_ar_len", 64'(ar_len), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        exp_bursts = 0;
        exp_stall  = 0;
        check_stats();
        @(negedge clk);
        reset = 1'b0;
        run_cmd(32'h0000_0000, 20'd1, 1'b0, 2'd2, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_req_splitter.md
# read_req_splitter

Upstream stage of `read_info`: accepts one read command per PU transfer (base address, length in beats, PU id, data type) and splits it into bounded bursts that never cross a 4 KB boundary. For each burst it reserves a `read_info` entry (`rd_req`, size, PU id, data type) before presenting the address on an AXI-style read-address channel. Because the reservation always comes first, `read_info` always knows a burst's routing before that burst's data can return.

## Interface
- `NUM_PU`, 1, number of processing units
- `D_TYPE_W`, 2, data-type tag width
- `RD_SIZE_W`, 20, command/request size width in beats
- `ADDR_W`, 32, byte address width
- `BURST_W`, 8, `ar_len` width
- `BEAT_BYTES`, 8, bytes per beat (power of 2)
- `MAX_BURST`, 16, max beats per burst (≤ 2^BURST_W, power of 2)
- `PU_ID_W`, `C_LOG_2(NUM_PU)+1`, PU id width
- `clk` in 1 — single clock
- `reset` in 1 — asynchronous, active-high
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — command accepted on `cmd_valid && cmd_ready`
- `cmd_addr` in ADDR_W — start byte address; low log2(BEAT_BYTES) bits ignored (treated as 0)
- `cmd_size` in RD_SIZE_W — total beats
- `cmd_pu_id` in PU_ID_W; `cmd_d_type` in D_TYPE_W — tags copied to every burst
- `read_info_full` in 1 — `read_info` cannot take a request
- `rd_req` out 1 — one-cycle reservation pulse to `read_info`
- `rd_req_size` out RD_SIZE_W; `rd_req_pu_id` out PU_ID_W; `rd_req_d_type` out D_TYPE_W — valid with `rd_req`
- `ar_valid` out 1; `ar_ready` in 1 — address handshake
- `ar_addr` out ADDR_W; `ar_len` out BURST_W — burst address, beats−1
- `done` out 1 — one-cycle pulse when a command completes
- `stat_bursts` out 32; `stat_stall_cycles` out 32 — see Configuration

## Operation
- FSM: IDLE → CALC → RESV → ADDR → (CALC | IDLE).
- IDLE: `cmd_ready`=1. On accept, latch addr/size/pu_id/d_type into `cur_addr`, `remaining`, tags. size==0 → stay IDLE, `done` pulse next cycle, no `rd_req`/`ar_valid`. Else → CALC.
- CALC: `bnd` = (4096 − cur_addr[11:0]) / BEAT_BYTES; `burst` = min(remaining, MAX_BURST, bnd), registered. → RESV.
- RESV: when `!read_info_full`, `rd_req`=1 for exactly this cycle with `rd_req_size`=burst (zero-extended), tags; → ADDR. While full: hold, no pulse.
- ADDR: `ar_valid`=1, `ar_addr`=cur_addr, `ar_len`=burst−1, all stable until `ar_ready`. On handshake: cur_addr += burst·BEAT_BYTES, remaining −= burst; remaining==0 → IDLE with `done` pulse, else → CALC.
- Exactly one `rd_req` per `ar_valid` handshake; order identical.
- Address arithmetic wraps modulo 2^ADDR_W; no overflow flag.

## Timing
- Reset values: `cmd_ready`=0, `rd_req`=0, `ar_valid`=0, `ar_addr`=0, `ar_len`=0, `rd_req_size/pu_id/d_type`=0, `done`=0, stats=0; state IDLE.
- `cmd_ready` is registered: 1 from first edge after reset release; cleared on the accept edge; set on the edge entering IDLE.
- Accept at edge T → CALC at T+1 → earliest `rd_req` at T+2 → earliest `ar_valid` at T+3.
- Back-to-back bursts: ar handshake at edge E → next `rd_req` at E+2 earliest.
- `rd_req` is combinational from RESV && !read_info_full; all other outputs registered.
- `ar_valid` never depends on `ar_ready` or `read_info_full`.
- `done` asserts the cycle after the last ar handshake; `cmd_ready` rises same cycle.
- Reset mid-command: command discarded, all outputs to reset values immediately.

## Configuration
- `READ_REQ_STATS_EN` defined: `stat_bursts` increments per ar handshake; `stat_stall_cycles` increments each cycle in RESV with `read_info_full`=1 or in ADDR with `ar_ready`=0; both saturate at 2^32−1, cleared only by reset.
- Undefined: both ports driven constant 0, counters not built.

## Test plan
- addr 0x1000, size 40 → rd_req sizes 16,16,8; ar_addr 0x1000/0x1080/0x1100, ar_len 15/15/7; one `done`.
- addr 0x1FC0, size 20 → bursts 8 @0x1FC0 (len 7), 12 @0x2000 (len 11).
- `read_info_full`=1 for 5 cycles in RESV → no `rd_req`, no `ar_valid`; release → single `rd_req` pulse, ar_valid next cycle; stall counter +5 with macro.
- `ar_ready`=0 for 3 cycles → `ar_valid`, `ar_addr`, `ar_len` stable; only one `rd_req` for that burst.
- size 0 → no `rd_req`/`ar_valid`, `done` one cycle after accept, `cmd_ready` high again same cycle.
- `reset` asserted during ADDR → `ar_valid`=0, `cmd_ready`=0 immediately; after release, new command addr 0x0, size 1 → one burst, ar_len 0.
